// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: default geometry,
// stage-count derivation and the WIDTH/SEG legality check.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEG   = 4;

    // Number of pipeline stages: one SEG-bit ripple segment per stage.
    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

    // Legal geometry: positive segment no wider than the word, dividing it evenly.
    function automatic bit seg_ok(input int width, input int seg);
        return (seg > 0) && (seg <= width) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; the building block of every ripple segment.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// SEG-bit combinational ripple-carry adder built from a chain of full adders.
module rca_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[SEG];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder with a valid/ready stream interface.
// Each stage adds one SEG-bit segment using the carry registered by the
// previous stage; not-yet-added operand bits ride along with the beat and
// finished sum bits accumulate, so one beat is accepted per cycle at a
// latency of WIDTH/SEG cycles. The whole pipe stalls as a unit when the
// output is held, so bubbles keep their position.
// Optional: define ADDER_OVF_DETECT_EN to add the signed-overflow output ovf.
module pipelined_ripple_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_DETECT_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int STAGES = stages_of(WIDTH, SEG);

    if (!seg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG");
    end

    logic              adv;
    logic              accept;
    logic [STAGES-1:0] vld_pipe;   // bit k: stage k holds a live beat

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign accept   = in_valid & in_ready;

    // Valid shift register: advances with the pipe, injecting a bubble when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe <= (vld_pipe << 1) | STAGES'(accept);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int DONE = (k + 1) * SEG;   // sum bits complete after this stage
        localparam int REM  = WIDTH - DONE;    // operand bits still to be added

        logic [SEG-1:0]  seg_a;
        logic [SEG-1:0]  seg_b;
        logic [SEG-1:0]  seg_s;
        logic            seg_ci;
        logic            seg_co;
        logic            vin;
        logic [DONE-1:0] s_next;
        logic [DONE-1:0] s_q;
        logic            c_q;

        if (k == 0) begin : g_head
            assign vin    = accept;
            assign seg_a  = a[SEG-1:0];
            assign seg_b  = b[SEG-1:0];
            assign seg_ci = cin;
            assign s_next = seg_s;
        end else begin : g_body
            assign vin    = vld_pipe[k-1];
            assign seg_a  = g_stg[k-1].g_rem.ar_q[SEG-1:0];
            assign seg_b  = g_stg[k-1].g_rem.br_q[SEG-1:0];
            assign seg_ci = g_stg[k-1].c_q;
            assign s_next = {seg_s, g_stg[k-1].s_q};
        end

        rca_segment #(.SEG(SEG)) u_seg (
            .a    (seg_a),
            .b    (seg_b),
            .cin  (seg_ci),
            .sum  (seg_s),
            .cout (seg_co)
        );

        // Capture finished sum bits and this segment's carry when a live beat moves in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv && vin) begin
                s_q <= s_next;
                c_q <= seg_co;
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] ar_q;
            logic [REM-1:0] br_q;
            logic [REM-1:0] ar_d;
            logic [REM-1:0] br_d;

            if (k == 0) begin : g_src
                assign ar_d = a[WIDTH-1:DONE];
                assign br_d = b[WIDTH-1:DONE];
            end else begin : g_src
                assign ar_d = g_stg[k-1].g_rem.ar_q[REM+SEG-1:SEG];
                assign br_d = g_stg[k-1].g_rem.br_q[REM+SEG-1:SEG];
            end

            // Skew the untouched upper operand bits so they meet their carry one stage later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ar_q <= '0;
                    br_q <= '0;
                end else if (adv && vin) begin
                    ar_q <= ar_d;
                    br_q <= br_d;
                end
            end
        end

`ifdef ADDER_OVF_DETECT_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            // Last segment sees the operand MSBs: flag same-sign inputs giving an opposite-sign sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && vin) begin
                    ovf_q <= (seg_a[SEG-1] == seg_b[SEG-1]) & (seg_s[SEG-1] != seg_a[SEG-1]);
                end
            end
        end
`endif
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;
`ifdef ADDER_OVF_DETECT_EN
    assign ovf       = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder: a 16/4 instance (4 stages) and an
// 8/8 instance (single stage). Overflow checks run when ADDER_OVF_DETECT_EN is defined.
module tb_pipelined_ripple_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
    logic [7:0]  a8, b8, sum8;

`ifdef ADDER_OVF_DETECT_EN
    logic        ovf, ovf8;
`endif

    int checks;
    int errors;

    pipelined_ripple_adder #(.WIDTH(16), .SEG(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef ADDER_OVF_DETECT_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    pipelined_ripple_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
`ifdef ADDER_OVF_DETECT_EN
        .cout      (cout8),
        .ovf       (ovf8)
`else
        .cout      (cout8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset16: out_valid=%b sum=%h cout=%b, want 0 0000 0", out_valid, sum, cout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
        end
        checks++;
        if (out_valid8 !== 1'b0 || sum8 !== 8'h0 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: out_valid=%b sum=%h cout=%b, want 0 00 0", out_valid8, sum8, cout8);
        end
`ifdef ADDER_OVF_DETECT_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
        end
`endif
        out_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    // One isolated beat on the 16-bit adder; result expected exactly 4 cycles later.
    task automatic test_single_beat(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                                    input logic tc, input logic [15:0] es, input logic ec);
        int lat;
        lat = -1;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb; cin = tc;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1 && lat < 0) begin
                lat = c;
                checks++;
                if (sum !== es || cout !== ec) begin
                    errors++;
                    $display("FAIL %s: sum=%h cout=%b, want %h %b", nm, sum, cout, es, ec);
                end
            end
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d, want 4", nm, lat);
        end
    endtask

    task automatic test_back_to_back;
        int got, first;
        logic [15:0] es;
        got = 0; first = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc < 8) begin
                in_valid = 1'b1; a = 16'(cyc); b = 16'(3 * cyc); cin = cyc[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready: cycle %0d in_ready=%b, want 1", cyc, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                checks++;
                if (got >= 8) begin
                    errors++;
                    $display("FAIL b2b_extra: result %0d beyond 8 beats, sum=%h", got, sum);
                end else begin
                    es = 16'(4 * got + (got & 1));
                    if (sum !== es || cout !== 1'b0 || cyc != first + got) begin
                        errors++;
                        $display("FAIL b2b_beat%0d: sum=%h cout=%b cycle %0d, want %h 0 cycle %0d",
                                 got, sum, cout, cyc, es, first + got);
                    end
                end
                got++;
            end
        end
        checks++;
        if (first != 4 || got != 8) begin
            errors++;
            $display("FAIL b2b_stream: first at %0d count %0d, want 4 and 8", first, got);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        logic        tc [6];
        logic [16:0] ev [6];
        int src, snk;
        for (int i = 0; i < 6; i++) begin
            ta[i] = 16'(16'h1111 * (i + 1));
            tb[i] = 16'hF0F0;
            tc[i] = i[0];
            ev[i] = {1'b0, ta[i]} + {1'b0, tb[i]} + {16'h0, tc[i]};
        end
        src = 0; snk = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 9);
            if (src < 6) begin
                in_valid = 1'b1; a = ta[src]; b = tb[src]; cin = tc[src];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 4 && cyc <= 8) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== ev[0]) begin
                    errors++;
                    $display("FAIL bp_stall: cycle %0d out_valid=%b in_ready=%b cout/sum=%h, want 1 0 %h",
                             cyc, out_valid, in_ready, {cout, sum}, ev[0]);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (snk >= 6) begin
                    errors++;
                    $display("FAIL bp_extra: result %0d cout/sum=%h beyond 6 beats", snk, {cout, sum});
                end else if ({cout, sum} !== ev[snk]) begin
                    errors++;
                    $display("FAIL bp_order%0d: cout/sum=%h, want %h", snk, {cout, sum}, ev[snk]);
                end
                snk++;
            end
            if (in_valid && in_ready === 1'b1) src++;
        end
        checks++;
        if (snk != 6) begin
            errors++;
            $display("FAIL bp_count: %0d results, want 6", snk);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight;
        bit stale;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 3); a = 16'(16'h0101 * (cyc + 1)); b = 16'h0F0F; cin = 1'b0;
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill: out_valid=%b, want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b sum=%h cout=%b in_ready=%b, want 0 0000 0 1",
                     out_valid, sum, cout, in_ready);
        end
        #4;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL mid_stale: out_valid seen %b after reset, want 0", stale);
        end
        test_single_beat("post_reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    endtask

`ifdef ADDER_OVF_DETECT_EN
    task automatic test_ovf_beat(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic [15:0] es, input logic ec, input logic eo);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb; cin = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (sum !== es || cout !== ec || ovf !== eo) begin
                    errors++;
                    $display("FAIL ovf_%h_%h: sum=%h cout=%b ovf=%b, want %h %b %b",
                             ta, tb, sum, cout, ovf, es, ec, eo);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ovf_timeout: no result for %h+%h", ta, tb);
        end
    endtask

    task automatic test_ovf;
        test_ovf_beat(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        test_ovf_beat(16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
        test_ovf_beat(16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
        test_ovf_beat(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    endtask
`endif

    // Single-stage instance: result one cycle after acceptance.
    task automatic test_single_stage(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                                     input logic [7:0] es, input logic ec);
        int lat;
        lat = -1;
        @(negedge clk);
        in_valid8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid8 = 1'b0;
            if (out_valid8 === 1'b1 && lat < 0) begin
                lat = c;
                checks++;
                if (sum8 !== es || cout8 !== ec) begin
                    errors++;
                    $display("FAIL seg8_%h_%h: sum=%h cout=%b, want %h %b", ta, tb, sum8, cout8, es, ec);
                end
            end
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL seg8_latency: got %0d, want 1", lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_beat("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        test_single_beat("max_plus_cin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        test_single_beat("mixed", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef ADDER_OVF_DETECT_EN
        test_ovf();
`endif
        test_single_stage(8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1);
        test_single_stage(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        test_single_stage(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined ripple-carry adder with a valid/ready stream interface. The WIDTH-bit add is split into SEG-bit ripple segments, one per pipeline stage. The carry is registered between stages and operands are skewed, so the adder accepts one operation per cycle at latency STAGES = WIDTH/SEG. It is the general-width, throughput-oriented successor to the fixed 4-bit ripple adder and feeds the lab datapath/ALU experiments.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG (1..WIDTH).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  adder can accept a beat this cycle.
a  in  WIDTH  operand A (unsigned or two's complement).
b  in  WIDTH  operand B.
cin  in  1  carry-in to bit 0.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the result.
sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  out  1  carry out of the MSB.
ovf  out  1  signed overflow; present only with ADDER_OVF_DETECT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid flags 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready follows its equation, so it is 1 during reset. Any beat in flight is discarded, with no partial output.
- Advance: adv = out_ready | ~out_valid. in_ready = adv. Accept when in_valid & in_ready.
- When adv=1, every stage register shifts one stage. Stage 0 loads the accepted beat, or a bubble (valid=0) if there is no accept.
- When adv=0, all stages hold. Bubbles do not collapse.
- Stage k (0..STAGES-1) adds operand bits [k*SEG +: SEG] with the carry registered from stage k-1 (cin for k=0). Sum bits for that segment are registered and forwarded. Higher operand segments are delayed along with the beat.
- Latency: a beat accepted in cycle t presents out_valid=1 in cycle t+STAGES, provided out_ready stays 1.
- Throughput: 1 beat/cycle when out_ready=1.
- Output: sum, cout (and ovf) are stable while out_valid=1 & out_ready=0. A result is consumed when out_valid & out_ready.
- Simultaneous consume and accept in the same cycle is legal, with no bubble inserted.
- Arithmetic: {cout,sum} = a + b + cin, with (WIDTH+1)-bit exact result. 2^WIDTH-1 + 2^WIDTH-1 + 1 gives sum=all-ones, cout=1.
- in_valid while in_ready=0: the beat is not taken, and the source must hold it (standard stream rule).
- Output registers hold their last value when out_valid=0; the bench treats them as don't-care.

Optional Feature:
ADDER_OVF_DETECT_EN:
- Defined: port ovf exists. ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), computed in the last stage, so the operand MSBs travel down the pipeline. ovf is valid with out_valid and reset to 0.
- Undefined: no ovf port and no MSB tracking registers.

Decomposition:
- Package pipelined_adder_pkg: localparam helper for STAGES and a function checking WIDTH % SEG == 0. Elaboration fails on violation.
- One sub-module, rca_segment: SEG-bit combinational ripple adder (a, b, cin -> sum, cout) built from the existing full-adder cell. It is instantiated STAGES times with a generate loop.
- Pipeline registers and handshake logic live in pipelined_ripple_adder.

Test Plan:
1. WIDTH=16, SEG=4: a=16'hFFFF, b=16'h0001, cin=0 accepted at t -> out_valid at t+4, sum=16'h0000, cout=1.
2. Back-to-back stream of 8 beats (a=i, b=3*i, cin=i[0]), out_ready=1 -> 8 consecutive out_valid cycles, each sum=4i+i[0], in_ready always 1.
3. Backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, sum/cout frozen. Release -> results in original order, none lost or duplicated.
4. Reset mid-operation: 3 beats in flight, rst_n pulsed low for half a cycle -> out_valid=0 immediately, no stale results afterwards. Next accepted beat appears with latency 4.
5. ADDER_OVF_DETECT_EN: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, cout=0. a=16'h8000, b=16'h8000 -> sum=0, ovf=1, cout=1.
6. WIDTH=8, SEG=8 (single stage): a=8'hA5, b=8'h5B, cin=1 -> latency 1, sum=8'h01, cout=1.
